cfg_bus_rr_arbiter: RTL and testbench

//  Shares one downstream cfg bus (addr/wdata + 1-cycle wr/rd pulse, ack/rdata) between NUM_REQ requesters.

---
 rtl/cfg_bus_rr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cfg_bus_rr_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_bus_rr_arbiter.sv
// cfg_bus_rr_arbiter: shares one cfg bus between NUM_REQ requesters.
// Round-robin grant, one transaction in flight, ack timeout -> error response.
module cfg_bus_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         cfg_addr,
  output logic [DATA_W-1:0]         cfg_wdata,
  output logic                      cfg_wr,
  output logic                      cfg_rd,
  input  logic                      cfg_ack,
  input  logic [DATA_W-1:0]         cfg_rdata,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [31:0]      ERR_WORD  = 32'hdead_beef;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_idx;
  logic               r_wr;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_err;
  logic [TMR_W-1:0]   r_timer;

  logic               w_any;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_tmo;
  logic               w_rsp_hs;

  function automatic logic [IDX_W-1:0] f_wrap(
    input logic [IDX_W-1:0] base,
    input int               step
  );
    int s;
    s = int'(base) + step;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Search starts one past the last served index, wrapping.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_any && req_valid[f_wrap(r_last, k)]) begin
        w_any     = 1'b1;
        w_gnt_idx = f_wrap(r_last, k);
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    if (w_any) w_gnt_oh[w_gnt_idx] = 1'b1;
  end

  assign w_tmo    = (r_timer == TMR_LAST);
  assign w_rsp_hs = rsp_ready[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = cfg_ack ? S_RESP : S_WAIT;
      S_WAIT:  if (cfg_ack || w_tmo) w_next = S_RESP;
      S_RESP:  if (w_rsp_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= LAST_INIT;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_timer <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx   <= w_gnt_idx;
            r_wr    <= req_wr[w_gnt_idx];
            r_addr  <= req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
            r_wdata <= req_wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          if (cfg_ack) begin
            r_rdata <= r_wr ? '0 : cfg_rdata;
            r_err   <= 1'b0;
          end
        end
        S_WAIT: begin
          // An ack in the final timer cycle still beats the timeout.
          if (cfg_ack) begin
            r_rdata <= r_wr ? '0 : cfg_rdata;
            r_err   <= 1'b0;
          end else if (w_tmo) begin
            r_rdata <= DATA_W'(ERR_WORD);
            r_err   <= 1'b1;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_RESP: begin
          if (w_rsp_hs) r_last <= r_idx;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    cfg_wr    = 1'b0;
    cfg_rd    = 1'b0;
    if (r_state == S_IDLE && !rst) req_ready = w_gnt_oh;
    if (r_state == S_RESP) rsp_valid = NUM_REQ'(1) << r_idx;
    if (r_state == S_ISSUE) begin
      cfg_wr = r_wr;
      cfg_rd = ~r_wr;
    end
    busy      = (r_state != S_IDLE);
    rsp_rdata = r_rdata;
    rsp_err   = r_err;
    cfg_addr  = r_addr;
    cfg_wdata = r_wdata;
  end

endmodule

// File: tb/tb_cfg_bus_rr_arbiter.sv
// tb_cfg_bus_rr_arbiter: directed stimulus with a cycle model
// of the arbiter checked against the DUT on every cycle.
module tb_cfg_bus_rr_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          cfg_wr;
  logic          cfg_rd;
  logic          cfg_ack;
  logic [DW-1:0] cfg_rdata;
  logic          busy;

  cfg_bus_rr_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
    .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h",
               nm, $time, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] rr_pick(
    input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j = (last + k) % N;
      if (v[j]) return N'(1) << j;
    end
    return '0;
  endfunction

  // ---------------- reference model ----------------
  bit          m_active, m_resp, m_wr, m_err;
  int          m_age, m_idx, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  task automatic m_clear();
    m_active = 0; m_resp = 0; m_wr = 0; m_err = 0;
    m_age = 0; m_idx = 0; m_last = N - 1;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  initial begin : model
    logic [N-1:0] e_ready, e_rspv;
    bit e_pulse;
    m_clear();
    forever begin
      @(negedge clk);
      if (rst) m_clear();
      e_ready = (rst || m_active) ? '0 : rr_pick(req_valid, m_last);
      e_pulse = !rst && m_active && !m_resp && m_age == 1;
      e_rspv  = (!rst && m_resp) ? N'(1) << m_idx : '0;
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rspv);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err",   rsp_err,   m_err);
      chk("cfg_addr",  cfg_addr,  m_addr);
      chk("cfg_wdata", cfg_wdata, m_wdata);
      chk("cfg_wr",    cfg_wr,    e_pulse && m_wr);
      chk("cfg_rd",    cfg_rd,    e_pulse && !m_wr);
      chk("busy",      busy,      m_active);
      if (!rst) begin
        if (!m_active) begin
          if (|req_valid) begin
            m_idx    = oh2i(e_ready);
            m_active = 1; m_resp = 0; m_age = 1;
            m_wr     = req_wr[m_idx];
            m_addr   = req_addr[m_idx*AW +: AW];
            m_wdata  = req_wdata[m_idx*DW +: DW];
          end
        end else if (!m_resp) begin
          if (cfg_ack) begin
            m_rdata = m_wr ? '0 : cfg_rdata;
            m_err = 0; m_resp = 1;
          end else if (m_age == TMO + 1) begin
            m_rdata = 32'hdead_beef;
            m_err = 1; m_resp = 1;
          end else begin
            m_age++;
          end
        end else if (rsp_ready[m_idx]) begin
          m_active = 0; m_resp = 0; m_last = m_idx;
        end
      end
    end
  end

  // ---------------- stimulus agents ----------------
  typedef struct {
    logic [N-1:0] m;
    int           lat;
    int           n;
    logic [31:0]  d;
    logic         e;
    bit           stable;
  } done_t;

  done_t done_q[$];
  int    log_q[$];
  int    acc_t[$];

  int cyc = 0;
  int ack_lat = -1;
  bit late_ack = 0;
  int hold_left = 0;
  logic [N-1:0] hold_mask = '0;
  int n_wr = 0, n_rd = 0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  int cur_t = 0, cur_n = 0;
  logic [31:0] cur_d = '0;
  logic cur_e = 1'b0;
  logic [N-1:0] cur_m = '0;
  bit cur_stable = 1;
  bit slv_on = 0;
  int slv_off = 0;

  logic [N-1:0] s_acc, s_rspv;
  logic s_busy, s_pulse;
  logic [31:0] s_rdata;

  task automatic step();
    done_t r;
    @(negedge clk);
    s_acc   = req_valid & req_ready;
    s_rspv  = rsp_valid;
    s_busy  = busy;
    s_pulse = cfg_wr | cfg_rd;
    s_rdata = rsp_rdata;
    if (s_acc != '0) begin
      log_q.push_back(oh2i(s_acc));
      acc_t.push_back(cyc);
      cur_t = cyc; cur_n = 0; cur_stable = 1;
    end
    if (cfg_wr) n_wr++;
    if (cfg_rd) n_rd++;
    if (s_pulse) begin
      p_addr = cfg_addr; p_wdata = cfg_wdata;
    end
    if (s_rspv != '0) begin
      if (cur_n == 0) begin
        cur_d = rsp_rdata; cur_e = rsp_err;
        cur_m = s_rspv; r.lat = cyc - cur_t;
        cur_t = r.lat;
      end else if (rsp_rdata !== cur_d || rsp_err !== cur_e) begin
        cur_stable = 0;
      end
      cur_n++;
      if ((s_rspv & rsp_ready) != '0) begin
        r.m = cur_m; r.lat = cur_t; r.n = cur_n;
        r.d = cur_d; r.e = cur_e; r.stable = cur_stable;
        done_q.push_back(r);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    req_valid = req_valid & ~s_acc;
    cfg_ack = 1'b0;
    if (s_acc != '0) begin
      slv_on = 1; slv_off = 0;
    end else if (slv_on) begin
      slv_off++;
    end
    if (slv_on && slv_off == ack_lat) begin
      cfg_ack = 1'b1; slv_on = 0;
    end
    if (late_ack && s_rspv != '0 && cur_n == 1) cfg_ack = 1'b1;
    if (hold_left > 0 && s_rspv != '0) hold_left--;
    rsp_ready = (hold_left > 0) ? hold_mask : '1;
  endtask

  task automatic wait_done(input int n, input int max, input string nm);
    int i = 0;
    while (done_q.size() < n && i < max) begin
      step(); i++;
    end
    chk(nm, done_q.size(), n);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin : stim
    int nd, k, i;
    rst = 1'b1;
    req_valid = '0; req_wr = '0;
    req_addr = '0; req_wdata = '0;
    rsp_ready = '1; cfg_ack = 1'b0; cfg_rdata = '0;
    step(); step(); step();
    rst = 1'b0;
    step();
    chk("rst_busy",  s_busy, 0);
    chk("rst_rspv",  s_rspv, 0);
    chk("rst_rdata", s_rdata, 0);

    // single write from requester 1, ack two cycles after pulse
    n_wr = 0; n_rd = 0; ack_lat = 2;
    req_wr = 4'b0010;
    req_addr[1*AW +: AW]  = 32'h0000_0104;
    req_wdata[1*DW +: DW] = 32'hA5A5_0001;
    req_valid = 4'b0010;
    wait_done(1, 30, "t1_done");
    chk("t1_grant", log_q[$], 1);
    chk("t1_nwr", n_wr, 1);
    chk("t1_nrd", n_rd, 0);
    chk("t1_addr", p_addr, 32'h0000_0104);
    chk("t1_wdata", p_wdata, 32'hA5A5_0001);
    chk("t1_lat", done_q[$].lat, 4);
    chk("t1_mask", done_q[$].m, 4'b0010);
    chk("t1_err", done_q[$].e, 0);
    chk("t1_data", done_q[$].d, 0);

    // arbitration order from reset, then all four at once
    do_reset();
    ack_lat = 1; req_wr = '0;
    cfg_rdata = 32'h0BAD_F00D;
    req_valid = 4'b0101;
    nd = done_q.size();
    wait_done(nd + 2, 40, "t2a_done");
    k = log_q.size();
    chk("t2a_first", log_q[k-2], 0);
    chk("t2a_second", log_q[k-1], 2);
    ack_lat = 0;
    req_valid = 4'b1111;
    wait_done(nd + 6, 60, "t2b_done");
    k = log_q.size();
    chk("t2b_o0", log_q[k-4], 3);
    chk("t2b_o1", log_q[k-3], 0);
    chk("t2b_o2", log_q[k-2], 1);
    chk("t2b_o3", log_q[k-1], 2);
    chk("t2b_gap1", acc_t[k-3] - acc_t[k-4], 3);
    chk("t2b_gap3", acc_t[k-1] - acc_t[k-2], 3);

    // zero-wait read from requester 3
    cfg_rdata = 32'h1234_5678; ack_lat = 0;
    req_valid = 4'b1000;
    nd = done_q.size();
    wait_done(nd + 1, 20, "t3_done");
    chk("t3_lat", done_q[$].lat, 2);
    chk("t3_data", done_q[$].d, 32'h1234_5678);
    chk("t3_err", done_q[$].e, 0);
    chk("t3_mask", done_q[$].m, 4'b1000);

    // timeout read, with an ack arriving during the response
    ack_lat = -1; late_ack = 1;
    hold_left = 2; hold_mask = '0; rsp_ready = '0;
    cfg_rdata = 32'hCAFE_0001;
    req_valid = 4'b0001;
    nd = done_q.size();
    wait_done(nd + 1, 400, "t4_done");
    late_ack = 0;
    chk("t4_lat", done_q[$].lat, TMO + 2);
    chk("t4_data", done_q[$].d, 32'hdead_beef);
    chk("t4_err", done_q[$].e, 1);
    chk("t4_stable", done_q[$].stable, 1);
    chk("t4_ncyc", done_q[$].n, 3);
    k = n_rd;
    cfg_ack = 1'b1;
    step(); step();
    chk("t4_idle_ack", s_busy, 0);
    chk("t4_no_pulse", n_rd, k);

    // response held off 10 cycles while another request waits
    n_wr = 0; ack_lat = 1;
    hold_left = 10; hold_mask = 4'b1011; rsp_ready = hold_mask;
    req_wr = 4'b0101;
    req_valid = 4'b0100;
    i = 0;
    while (s_rspv == '0 && i < 20) begin
      step(); i++;
    end
    chk("t5_rsp_seen", s_rspv, 4'b0100);
    req_valid[0] = 1'b1;
    nd = done_q.size();
    wait_done(nd + 2, 60, "t5_done");
    k = log_q.size();
    chk("t5_ncyc", done_q[nd].n, 11);
    chk("t5_stable", done_q[nd].stable, 1);
    chk("t5_gap", acc_t[k-1] - acc_t[k-2], 14);
    chk("t5_order", log_q[k-1], 0);
    chk("t5_nwr", n_wr, 2);

    // reset while waiting for an ack
    ack_lat = -1; req_wr = '0;
    req_valid = 4'b0010;
    i = 0;
    while (!s_pulse && i < 10) begin
      step(); i++;
    end
    step(); step();
    chk("t6_busy_pre", s_busy, 1);
    rst = 1'b1;
    step();
    chk("t6_busy", s_busy, 0);
    chk("t6_rspv", s_rspv, 0);
    chk("t6_pulse", s_pulse, 0);
    k  = n_rd;
    nd = done_q.size();
    rst = 1'b0;
    repeat (5) step();
    chk("t6_no_pulse", n_rd, k);
    chk("t6_no_rsp", done_q.size(), nd);
    ack_lat = 1;
    req_valid = 4'b0101;
    wait_done(nd + 2, 40, "t6_done");
    k = log_q.size();
    chk("t6_first", log_q[k-2], 0);
    chk("t6_second", log_q[k-1], 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=done",
             $time);
    $fatal(1, "watchdog expired");
  end

endmodule
